// File: rtl/memory_if.sv
// ============================================================================
//  Module      : memory_if
//  Description : Coordinate-addressed access bundle for the matrix memory.
//                MEMORY_ADDR_ERR_EN adds the addr_err status signal.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        matrix_select;
    logic [1:0]        row;
    logic [1:0]        col;
    logic              write_enable;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
`ifdef MEMORY_ADDR_ERR_EN
    logic              addr_err;

    modport master (
        output matrix_select, row, col, write_enable, write_data,
        input  read_data, addr_err
    );
    modport slave (
        input  matrix_select, row, col, write_enable, write_data,
        output read_data, addr_err
    );
`else
    modport master (
        output matrix_select, row, col, write_enable, write_data,
        input  read_data
    );
    modport slave (
        input  matrix_select, row, col, write_enable, write_data,
        output read_data
    );
`endif
endinterface

`default_nettype wire

// File: rtl/memory.sv
// ============================================================================
//  Module      : memory
//  Description : Bank of small matrices, one (matrix,row,col) access per clock,
//                synchronous write-first, 1-cycle registered read.
//                Optional macro MEMORY_ADDR_ERR_EN adds a registered addr_err.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory #(
    parameter int NUM_MATRICES = 4,
    parameter int ROWS         = 3,
    parameter int COLS         = 3,
    parameter int DATA_W       = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    memory_if.slave   bus
);

    localparam int C_DEPTH = NUM_MATRICES * ROWS * COLS;

    logic [C_DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [DATA_W-1:0]              rdata_q;
    logic [DATA_W-1:0]              rdata_d;
    logic [DATA_W-1:0]              w_rd;
    logic [7:0]                     w_lin;
    logic                           w_valid;
    logic [C_DEPTH-1:0]             w_hit;

    assign w_valid = (32'(bus.matrix_select) < NUM_MATRICES) &&
                     (32'(bus.row) < ROWS) &&
                     (32'(bus.col) < COLS);

    assign w_lin = (8'(bus.matrix_select) * 8'(ROWS) + 8'(bus.row)) * 8'(COLS)
                 + 8'(bus.col);

    // One-hot entry decode; an invalid address selects nothing.
    for (genvar gi = 0; gi < C_DEPTH; gi++) begin : g_hit
        assign w_hit[gi] = w_valid && (w_lin == 8'(gi));
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < C_DEPTH; i++) begin
            if (w_hit[i]) begin
                w_rd = mem_q[i];
            end
        end
    end

    // Write-first: a same-edge write of the read address forwards write_data.
    always_comb begin
        rdata_d = '0;
        if (w_valid) begin
            rdata_d = bus.write_enable ? bus.write_data : w_rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q   <= '0;
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < C_DEPTH; i++) begin
                if (bus.write_enable && w_hit[i]) begin
                    mem_q[i] <= bus.write_data;
                end
            end
            rdata_q <= rdata_d;
        end
    end

    assign bus.read_data = rdata_q;

`ifdef MEMORY_ADDR_ERR_EN
    logic addr_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= ~w_valid;
        end
    end

    assign bus.addr_err = addr_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory.sv
// ============================================================================
//  Module      : tb_memory
//  Description : Randomised scoreboard bench for the matrix memory against a
//                3-D array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory;

    localparam int NUM_M  = 4;
    localparam int ROWS   = 3;
    localparam int COLS   = 3;
    localparam int DATA_W = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        string             name;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    exp_t              sb[$];
    logic [DATA_W-1:0] model [4][4][4];

    memory_if #(.DATA_W(DATA_W)) bus ();

    memory #(
        .NUM_MATRICES(NUM_M),
        .ROWS        (ROWS),
        .COLS        (COLS),
        .DATA_W      (DATA_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each negedge shows the result of the preceding rising edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.read_data !== e.data) begin
                errors++;
                $display("FAIL %s read_data actual=%0h required=%0h", e.name, bus.read_data, e.data);
            end
`ifdef MEMORY_ADDR_ERR_EN
            checks++;
            if (bus.addr_err !== e.err) begin
                errors++;
                $display("FAIL %s addr_err actual=%0b required=%0b", e.name, bus.addr_err, e.err);
            end
`endif
        end
    end

    task automatic model_clear();
        for (int m = 0; m < 4; m++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    model[m][r][c] = '0;
    endtask

    task automatic do_cycle(input logic [1:0] ms, input logic [1:0] r, input logic [1:0] c,
                            input logic we, input logic [DATA_W-1:0] wd, input string name);
        exp_t e;
        bit   v;
        bus.matrix_select = ms;
        bus.row           = r;
        bus.col           = c;
        bus.write_enable  = we;
        bus.write_data    = wd;
        v = (int'(ms) < NUM_M) && (int'(r) < ROWS) && (int'(c) < COLS);
        if (!v)      e.data = '0;
        else if (we) e.data = wd;
        else         e.data = model[ms][r][c];
        e.err  = !v;
        e.name = name;
        if (v && we) model[ms][r][c] = wd;
        @(posedge clk);
        sb.push_back(e);
        #1;
    endtask

    // Scans the whole 2-bit coordinate space, invalid rows/cols included.
    task automatic read_all(input string name);
        for (int m = 0; m < 4; m++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    do_cycle(2'(m), 2'(r), 2'(c), 1'b0, '0, name);
    endtask

    task automatic check_direct(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.matrix_select = '0;
        bus.row           = '0;
        bus.col           = '0;
        bus.write_enable  = 1'b0;
        bus.write_data    = '0;
        model_clear();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_direct("reset_rdata", bus.read_data, '0);
`ifdef MEMORY_ADDR_ERR_EN
        check_direct("reset_addr_err", 8'(bus.addr_err), '0);
`endif
        reset = 1'b1;

        read_all("reset_readall");

        for (int i = 0; i < 9; i++)
            do_cycle(2'd0, 2'(i / 3), 2'(i % 3), 1'b1, 8'(i + 1), "m0_fill");
        for (int i = 0; i < 9; i++)
            do_cycle(2'd0, 2'(i / 3), 2'(i % 3), 1'b0, '0, "m0_readback");

        do_cycle(2'd1, 2'd2, 2'd2, 1'b1, 8'hAA, "iso_wr_aa");
        do_cycle(2'd3, 2'd0, 2'd0, 1'b1, 8'h55, "iso_wr_55");
        read_all("iso_readall");

        do_cycle(2'd2, 2'd1, 2'd1, 1'b1, 8'd77, "wr_first");
        do_cycle(2'd2, 2'd1, 2'd1, 1'b0, '0, "wr_first_idle");

        do_cycle(2'd0, 2'd3, 2'd0, 1'b1, 8'hFF, "inv_wr_row");
        do_cycle(2'd0, 2'd0, 2'd3, 1'b1, 8'hFF, "inv_wr_col");
        do_cycle(2'd0, 2'd3, 2'd0, 1'b0, '0, "inv_rd");
        do_cycle(2'd0, 2'd0, 2'd0, 1'b0, '0, "inv_after");
        read_all("inv_readall");

        for (int i = 0; i < 400; i++)
            do_cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     8'($urandom), "random");

        // Write burst interrupted by reset between edges.
        for (int i = 0; i < 5; i++)
            do_cycle(2'd1, 2'(i % 3), 2'((i + 1) % 3), 1'b1, 8'(8'hC0 + i), "burst");
        #2;
        sb.delete();
        reset = 1'b0;
        model_clear();
        #1;
        check_direct("async_rst_rdata", bus.read_data, '0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        read_all("post_rst_readall");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
